lcd_write_arbiter: RTL
======================

LCD_WRITE_ARBITER -- requirements
Module: lcd_write_arbiter

Interface
REQ-001 Parameter RESET_CYCLES, default 16: number of cycles oLCD_reset is held high after Reset or a timeout.
REQ-002 Parameter TIMEOUT, default 255: maximum wait, in cycles, for any iLCD_response edge; counter is 8 bits wide.
REQ-003 Clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 iReq0 / iReq1  input  1 each  level request from requester 0 / 1 to write one byte.
REQ-006 iData0 / iData1  input  8 each  byte from requester 0 / 1; must be stable while its iReq is high.
REQ-007 oGnt0 / oGnt1  output  1 each  high while the byte from requester 0 / 1 is in transfer.
REQ-008 oDone0 / oDone1  output  1 each  one-cycle pulse when requester 0 / 1's byte has fully transferred.
REQ-009 oErr  output  1  sticky timeout flag.
REQ-010 oLCD_data  output  4  nibble to the LCD controller.
REQ-011 oLCD_writeEN  output  1  nibble-valid strobe to the LCD controller.
REQ-012 oLCD_reset  output  1  reset request to the LCD controller.
REQ-013 iLCD_response  input  1  acknowledge from the LCD controller.

Function
REQ-014 The FSM SHALL have exactly these states: INIT, IDLE, HI_REQ, HI_REL, LO_REQ, LO_REL, DONE.
REQ-015 In INIT, oLCD_reset SHALL be 1 for exactly RESET_CYCLES cycles; the FSM SHALL then enter IDLE, and oLCD_reset SHALL be 0 in every other state.
REQ-016 In IDLE with any iReq high, the FSM SHALL pick a winner, latch its iData into an 8-bit register, assert its oGnt and enter HI_REQ on the next edge.
REQ-017 Arbitration: with a single requester, that requester wins; with both, the requester not served last wins; after reset, the last-served pointer SHALL equal 1 so that requester 0 wins first.
REQ-018 HI_REQ SHALL drive oLCD_data = latched[7:4] with oLCD_writeEN = 1, and move to HI_REL on the first cycle iLCD_response = 1.
REQ-019 HI_REL SHALL drive oLCD_writeEN = 0 with oLCD_data held, and move to LO_REQ on the first cycle iLCD_response = 0.
REQ-020 LO_REQ and LO_REL SHALL behave as HI_REQ and HI_REL using latched[3:0]; LO_REL SHALL exit to DONE.
REQ-021 DONE SHALL last one cycle, pulse oDone of the granted requester, deassert oGnt, update the last-served pointer and return to IDLE.
REQ-022 oGnt SHALL be high from the cycle after the grant through DONE inclusive; at most one oGnt SHALL be high at any time.
REQ-023 A requester still holding iReq high in IDLE after its DONE SHALL be treated as a new request, subject to REQ-017.
REQ-024 Changes on iReq or iData after the grant SHALL NOT affect the transfer in progress.
REQ-025 A wait counter SHALL clear on entry to each REQ/REL state and increment each cycle in that state.
REQ-026 If the wait counter reaches TIMEOUT, the FSM SHALL: set oErr, drive oLCD_writeEN = 0, deassert oGnt, enter INIT, give no oDone pulse, and leave the last-served pointer unchanged.
REQ-027 oLCD_data SHALL be 0 in INIT and IDLE.

Reset
REQ-028 While Reset is high: state = INIT (counter restarted), oLCD_reset = 1, oLCD_writeEN = 0, oLCD_data = 0, oGnt0/1 = 0, oDone0/1 = 0, oErr = 0, last-served pointer = 1.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer with no oDone pulse; the requester must re-request afterwards.
REQ-030 oErr SHALL clear only on Reset.

Verification
REQ-031 Reset pulse for 1 cycle -> oLCD_reset high for 16 cycles, then IDLE with all outputs 0.
REQ-032 iReq0 = 1 with iData0 = 0xA5, and an LCD model acking after 3 cycles -> nibbles 0xA then 0x5, each with full four-phase writeEN/response handshake, then one oDone0 pulse.
REQ-033 iReq0 and iReq1 both held high -> grants alternate 0, 1, 0, 1; exactly one oDone per byte.
REQ-034 iLCD_response held at 0 -> after 255 cycles in HI_REQ: oErr = 1, oLCD_writeEN = 0, 16-cycle oLCD_reset, then requester 0 served again.
REQ-035 Reset asserted during LO_REQ -> no oDone; next cycle state = INIT with all outputs at their reset values.
REQ-036 iData1 changed from 0x3C to 0xFF after grant -> LCD still receives 0x3 then 0xC.

Source files
------------

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: two-requester byte arbiter that sends each byte to an LCD controller as two nibbles
// over a four-phase writeEN/response handshake. It has a wait timeout and a timed controller reset.
module lcd_write_arbiter #(
    parameter int RESET_CYCLES = 16,
    parameter int TIMEOUT      = 255
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iReq0,
    input  logic       iReq1,
    input  logic [7:0] iData0,
    input  logic [7:0] iData1,
    output logic       oGnt0,
    output logic       oGnt1,
    output logic       oDone0,
    output logic       oDone1,
    output logic       oErr,
    output logic [3:0] oLCD_data,
    output logic       oLCD_writeEN,
    output logic       oLCD_reset,
    input  logic       iLCD_response
);
    typedef enum logic [2:0] {INIT, IDLE, HI_REQ, HI_REL, LO_REQ, LO_REL, DONE} state_t;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_byte;
    logic       r_sel;
    logic       r_last;

    logic       w_sel;
    logic [7:0] w_data;
    logic       w_wait;
    logic       w_go;
    logic       w_tout;

    // Round-robin only matters when both requesters are active.
    assign w_sel  = (iReq0 && iReq1) ? ~r_last : iReq1;
    assign w_data = w_sel ? iData1 : iData0;
    assign w_wait = (r_state == HI_REQ) || (r_state == HI_REL) || (r_state == LO_REQ) || (r_state == LO_REL);
    assign w_go   = ((r_state == HI_REQ) || (r_state == LO_REQ)) ? iLCD_response : !iLCD_response;
    assign w_tout = (r_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state      <= INIT;
            r_cnt        <= 8'd0;
            r_byte       <= 8'd0;
            r_sel        <= 1'b0;
            r_last       <= 1'b1;
            oGnt0        <= 1'b0;
            oGnt1        <= 1'b0;
            oDone0       <= 1'b0;
            oDone1       <= 1'b0;
            oErr         <= 1'b0;
            oLCD_data    <= 4'd0;
            oLCD_writeEN <= 1'b0;
            oLCD_reset   <= 1'b1;
        end else begin
            oDone0 <= 1'b0;
            oDone1 <= 1'b0;
            if (w_wait && !w_go && w_tout) begin
                r_state      <= INIT;
                r_cnt        <= 8'd0;
                oErr         <= 1'b1;
                oGnt0        <= 1'b0;
                oGnt1        <= 1'b0;
                oLCD_data    <= 4'd0;
                oLCD_writeEN <= 1'b0;
                oLCD_reset   <= 1'b1;
            end else begin
                case (r_state)
                    INIT: begin
                        if (r_cnt == 8'(RESET_CYCLES - 1)) begin
                            r_state    <= IDLE;
                            oLCD_reset <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    IDLE: begin
                        if (iReq0 || iReq1) begin
                            r_state      <= HI_REQ;
                            r_cnt        <= 8'd0;
                            r_sel        <= w_sel;
                            r_byte       <= w_data;
                            oGnt0        <= ~w_sel;
                            oGnt1        <= w_sel;
                            oLCD_data    <= w_data[7:4];
                            oLCD_writeEN <= 1'b1;
                        end
                    end
                    HI_REQ, LO_REQ: begin
                        if (w_go) begin
                            r_state      <= (r_state == HI_REQ) ? HI_REL : LO_REL;
                            r_cnt        <= 8'd0;
                            oLCD_writeEN <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    HI_REL: begin
                        if (w_go) begin
                            r_state      <= LO_REQ;
                            r_cnt        <= 8'd0;
                            oLCD_data    <= r_byte[3:0];
                            oLCD_writeEN <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    LO_REL: begin
                        if (w_go) begin
                            r_state <= DONE;
                            oDone0  <= ~r_sel;
                            oDone1  <= r_sel;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    DONE: begin
                        r_state   <= IDLE;
                        r_last    <= r_sel;
                        oGnt0     <= 1'b0;
                        oGnt1     <= 1'b0;
                        oLCD_data <= 4'd0;
                    end
                    default: r_state <= INIT;
                endcase
            end
        end
    end
endmodule
